// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/long-press/repeat
// strobes plus a held level, for one button feeding the game control FSM.
module button_event_decoder #(
   parameter int                   CNT_WIDTH    = 26,
   parameter logic [CNT_WIDTH-1:0] HOLD_TICKS   = 26'd50_000_000,
   parameter logic [CNT_WIDTH-1:0] REPEAT_TICKS = 26'd10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic button_in,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press,
   output logic repeat_pulse,
   output logic held
);

   localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = HOLD_TICKS - 1'b1;
   localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = REPEAT_TICKS - 1'b1;

   typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_nxt;
   logic                 btn_p0;
   logic                 btn_p1;
   logic                 rise;
   logic                 hold_hit;
   logic                 repeat_hit;
   logic                 press_nxt;
   logic                 release_nxt;
   logic                 long_nxt;
   logic                 repeat_nxt;

   assign rise       = btn_p0 & ~btn_p1;
   assign hold_hit   = (cnt == HOLD_LAST);
   assign repeat_hit = (cnt == REPEAT_LAST);

   // Stage p0/p1 preset high: a button already down at reset must go low before it counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_p0        <= 1'b1;
         btn_p1        <= 1'b1;
         state         <= IDLE;
         cnt           <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;
         repeat_pulse  <= 1'b0;
         held          <= 1'b0;
      end else begin
         btn_p0        <= button_in;
         btn_p1        <= btn_p0;
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
         long_press    <= long_nxt;
         repeat_pulse  <= repeat_nxt;
         held          <= (state_nxt != IDLE);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (rise) begin
               state_nxt = PRESS;
               cnt_nxt   = '0;
            end
         end
         PRESS: begin
            if (!btn_p0) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (hold_hit) begin
               state_nxt = HOLD;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         HOLD: begin
            if (!btn_p0) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (repeat_hit) begin
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Release is tested first so it beats a threshold reached in the same cycle.
   always_comb begin
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;
      repeat_nxt  = 1'b0;
      case (state)
         IDLE:  press_nxt = rise;
         PRESS: begin
            release_nxt = ~btn_p0;
            long_nxt    = btn_p0 & hold_hit;
         end
         HOLD: begin
            release_nxt = ~btn_p0;
            repeat_nxt  = btn_p0 & repeat_hit;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboarded bench for button_event_decoder: directed scenarios plus random
// button runs, checked against a press-age model of the event rules.
module tb_button_event_decoder;

   localparam int CW = 4;
   localparam int H  = 8;
   localparam int R  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic button_in = 1'b0;
   logic press_pulse, release_pulse, long_press, repeat_pulse, held;

   button_event_decoder #(
      .CNT_WIDTH   (CW),
      .HOLD_TICKS  (4'(H)),
      .REPEAT_TICKS(4'(R))
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .button_in    (button_in),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_press   (long_press),
      .repeat_pulse (repeat_pulse),
      .held         (held)
   );

   always #5 clk = ~clk;

   // expected word: {press, release, long, repeat, held}
   logic [4:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   // model: last two sampled levels and age of the current accepted press
   logic m_s = 1'b1;
   logic m_p = 1'b1;
   bit   m_act = 1'b0;
   int   m_age = 0;

   task automatic step(input logic b, input logic r);
      logic [4:0] e;
      @(negedge clk);
      button_in = b;
      rst       = r;
      e = '0;
      if (r) begin
         m_s = 1'b1; m_p = 1'b1; m_act = 1'b0; m_age = 0;
      end else begin
         if (m_act) begin
            if (!m_s) begin
               e[3] = 1'b1;
               m_act = 1'b0;
            end else begin
               m_age++;
               if (m_age == H) e[2] = 1'b1;
               else if (m_age > H && ((m_age - H) % R) == 0) e[1] = 1'b1;
            end
         end else if (m_s && !m_p) begin
            e[4] = 1'b1;
            m_act = 1'b1;
            m_age = 0;
         end
         e[0] = m_act;
         m_p = m_s;
         m_s = b;
      end
      exp_q.push_back(e);
      if (r) begin
         #1;
         n_vec++;
         if ({press_pulse, release_pulse, long_press, repeat_pulse, held} != 5'b0) begin
            n_err++;
            $display("FAIL async_reset: got %b want 00000",
                     {press_pulse, release_pulse, long_press, repeat_pulse, held});
         end
      end
   endtask

   task automatic run(input logic b, input int n);
      for (int i = 0; i < n; i++) step(b, 1'b0);
   endtask

   // monitor: one popped expectation per clock edge
   always begin
      logic [4:0] act, want;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         want = exp_q.pop_front();
         act  = {press_pulse, release_pulse, long_press, repeat_pulse, held};
         n_vec++;
         if (act !== want) begin
            n_err++;
            $display("FAIL events @%0t: got {prs,rel,lng,rep,held}=%b want %b", $time, act, want);
         end
      end
   end

   initial begin
      // short press
      step(1'b0, 1'b1); step(1'b0, 1'b1);
      run(1'b0, 5); run(1'b1, 3); run(1'b0, 5);
      // long hold with repeats
      run(1'b1, 30); run(1'b0, 3);
      // held through reset must not count as a press
      step(1'b1, 1'b1); step(1'b1, 1'b1);
      run(1'b1, 10); run(1'b0, 2); run(1'b1, 5); run(1'b0, 3);
      // release around the hold threshold
      run(1'b1, 7); run(1'b0, 3);
      run(1'b1, 8); run(1'b0, 3);
      run(1'b1, 9); run(1'b0, 3);
      // release around a repeat threshold
      run(1'b1, 12); run(1'b0, 3);
      run(1'b1, 13); run(1'b0, 3);
      // reset while in HOLD, button stays down
      run(1'b1, 20); step(1'b1, 1'b1);
      run(1'b1, 10); run(1'b0, 2); run(1'b1, 3); run(1'b0, 3);
      // one-cycle toggling
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0); step(1'b0, 1'b0);
      end
      run(1'b0, 3);
      // random runs with occasional reset
      for (int k = 0; k < 40; k++) begin
         logic lvl;
         int   len;
         lvl = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 30);
         for (int i = 0; i < len; i++)
            step(lvl, ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
      end
      run(1'b0, 3);
      repeat (3) @(posedge clk);
      #2;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
